// File: rtl/uart_apb_cmd_bridge.sv
// Framed UART command decoder driving a single APB master port.
// Each frame is a command byte, a big-endian address and, for writes, big-endian data; the reply is ACK/NAK plus any read data.
module uart_apb_cmd_bridge #(
  parameter int ADDR_BYTES     = 2,
  parameter int DATA_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_data_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_data_valid,
  input  logic                    tx_ready,
  output logic [8*ADDR_BYTES-1:0] PADDR,
  output logic [8*DATA_BYTES-1:0] PWDATA,
  output logic                    PWRITE,
  output logic                    PSEL,
  output logic                    PENABLE,
  input  logic                    PREADY,
  input  logic [8*DATA_BYTES-1:0] PRDATA,
  input  logic                    PSLVERR,
  output logic                    busy
);

  localparam int AW   = 8 * ADDR_BYTES;
  localparam int DW   = 8 * DATA_BYTES;
  localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int RW   = $clog2(DATA_BYTES + 2);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  localparam logic [2:0] S_CMD    = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_WDATA  = 3'd2;
  localparam logic [2:0] S_SETUP  = 3'd3;
  localparam logic [2:0] S_ACCESS = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] byte_cnt;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] rdata_reg;
  logic          write_reg;
  logic [7:0]    resp_code;
  logic [RW-1:0] resp_idx;
  logic [RW-1:0] resp_last;
  logic [TW-1:0] tmo_cnt;

  logic [7:0] data_byte [DATA_BYTES];
  logic [7:0] resp_byte;

  // Captured read data, split MSB-first so response byte k+1 is data_byte[k].
  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_rbytes
    assign data_byte[gi] = rdata_reg[DW-1-8*gi -: 8];
  end

  always_comb begin
    resp_byte = resp_code;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (resp_idx == RW'(i + 1)) resp_byte = data_byte[i];
    end
  end

  assign tx_data_valid = (state == S_RESP);
  assign tx_data       = (state == S_RESP) ? resp_byte : 8'h00;
  assign PSEL          = (state == S_SETUP) || (state == S_ACCESS);
  assign PENABLE       = (state == S_ACCESS);
  assign PADDR         = addr_reg;
  assign PWDATA        = wdata_reg;
  assign PWRITE        = write_reg;
  assign busy          = (state != S_CMD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_CMD;
      byte_cnt  <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      write_reg <= 1'b0;
      resp_code <= 8'h00;
      resp_idx  <= '0;
      resp_last <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        S_CMD: begin
          if (rx_data_valid) begin
            byte_cnt <= '0;
            resp_idx <= '0;
            if (rx_data == CMD_WRITE) begin
              write_reg <= 1'b1;
              state     <= S_ADDR;
            end else if (rx_data == CMD_READ) begin
              write_reg <= 1'b0;
              state     <= S_ADDR;
            end else begin
              resp_code <= RSP_NAK;
              resp_last <= '0;
              state     <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (rx_data_valid) begin
            addr_reg <= (addr_reg << 8) | AW'(rx_data);
            if (byte_cnt == CW'(ADDR_BYTES - 1)) begin
              byte_cnt <= '0;
              state    <= write_reg ? S_WDATA : S_SETUP;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end

        S_WDATA: begin
          if (rx_data_valid) begin
            wdata_reg <= (wdata_reg << 8) | DW'(rx_data);
            if (byte_cnt == CW'(DATA_BYTES - 1)) begin
              byte_cnt <= '0;
              state    <= S_SETUP;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end

        S_SETUP: begin
          tmo_cnt <= '0;
          state   <= S_ACCESS;
        end

        S_ACCESS: begin
          if (PREADY) begin
            if (!write_reg) rdata_reg <= PRDATA;
            resp_idx <= '0;
            state    <= S_RESP;
            if (PSLVERR) begin
              resp_code <= RSP_NAK;
              resp_last <= '0;
            end else begin
              resp_code <= RSP_ACK;
              resp_last <= write_reg ? RW'(0) : RW'(DATA_BYTES);
            end
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // Slave never answered: abandon the transfer and report NAK.
            resp_idx  <= '0;
            resp_code <= RSP_NAK;
            resp_last <= '0;
            state     <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (tx_ready) begin
            if (resp_idx == resp_last) begin
              resp_idx <= '0;
              state    <= S_CMD;
            end else begin
              resp_idx <= resp_idx + 1'b1;
            end
          end
        end

        default: state <= S_CMD;
      endcase
    end
  end

endmodule
